// File: rtl/rom_stream_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rom_stream_reader_if                                      |
// | Purpose  : Command, ROM read port and output stream bundle for       |
// |            rom_stream_reader. The ROM_STREAM_ADDR_CHECK_EN macro     |
// |            adds the address-return check signals.                    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface rom_stream_reader_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
);
  localparam int ADDRW = $clog2(DEPTH);

  // command / status
  logic             start;
  logic [ADDRW-1:0] base;
  logic [ADDRW:0]   len;
  logic             busy;
  logic             done;
  // ROM read port
  logic [ADDRW-1:0] rom_addr;
  logic [WIDTH-1:0] rom_data;
  // output stream
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

`ifdef ROM_STREAM_ADDR_CHECK_EN
  logic [ADDRW-1:0] rom_addr_return;
  logic             addr_err;

  modport master (
    input  start, base, len, rom_data, out_ready, rom_addr_return,
    output busy, done, rom_addr, out_data, out_valid, addr_err
  );
  modport slave (
    output start, base, len, rom_data, out_ready, rom_addr_return,
    input  busy, done, rom_addr, out_data, out_valid, addr_err
  );
`else
  modport master (
    input  start, base, len, rom_data, out_ready,
    output busy, done, rom_addr, out_data, out_valid
  );
  modport slave (
    output start, base, len, rom_data, out_ready,
    input  busy, done, rom_addr, out_data, out_valid
  );
`endif
endinterface
`default_nettype wire

// File: rtl/rom_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rom_stream_reader                                         |
// | Purpose  : Walks base..base+len-1 (mod DEPTH) of a 1-cycle-latency   |
// |            ROM and streams the words out through a small FIFO with   |
// |            valid/ready. Optional macro ROM_STREAM_ADDR_CHECK_EN adds |
// |            a sticky returned-address mismatch flag (addr_err).       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module rom_stream_reader #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  rom_stream_reader_if.master bus
);
  localparam int ADDRW = $clog2(DEPTH);
  localparam int PTRW  = $clog2(FIFO_DEPTH);
  localparam int CNTW  = PTRW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [ADDRW-1:0] r_next_addr;   // next address to issue
  logic [ADDRW-1:0] r_last_addr;   // most recently issued address (held on rom_addr)
  logic [ADDRW:0]   r_remaining;   // addresses still to issue
  logic             r_inflight;    // a read was issued last cycle; its data arrives now
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTRW-1:0]  r_wr_ptr;
  logic [PTRW-1:0]  r_rd_ptr;
  logic [CNTW-1:0]  r_count;

  logic             w_issue;
  logic             w_last_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_busy;
  logic             w_done;
  logic [CNTW-1:0]  w_occupancy;

  // FIFO words plus the word still in flight; at most FIFO_DEPTH+1, fits CNTW bits
  assign w_occupancy  = r_count + CNTW'(r_inflight);
  assign w_last_issue = w_issue && (r_remaining == (ADDRW+1)'(1));
  assign w_push       = r_inflight;
  assign w_pop        = (r_count != '0) && bus.out_ready;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = (bus.len == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (w_last_issue) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!r_inflight && (r_count == '0)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: read issue gated by FIFO space counting the in-flight word
  always_comb begin
    w_issue = (r_state == S_FETCH) && (w_occupancy < CNTW'(FIFO_DEPTH));
    w_busy  = (r_state == S_FETCH) || (r_state == S_DRAIN);
    w_done  = (r_state == S_DONE);
  end

  // address walker, in-flight tracking and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_next_addr <= '0;
      r_last_addr <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      if ((r_state == S_IDLE) && bus.start) begin
        r_next_addr <= bus.base;
        r_remaining <= bus.len;
      end else if (w_issue) begin
        r_last_addr <= r_next_addr;
        r_next_addr <= (r_next_addr == ADDRW'(DEPTH-1)) ? '0 : r_next_addr + ADDRW'(1);
        r_remaining <= r_remaining - (ADDRW+1)'(1);
      end
      r_inflight <= w_issue;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTRW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTRW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are masked by r_count so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.rom_data;
  end

  // the issued address goes out combinationally in its issue cycle, then holds
  assign bus.rom_addr  = w_issue ? r_next_addr : r_last_addr;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;

`ifdef ROM_STREAM_ADDR_CHECK_EN
  logic r_addr_err;

  // sticky flag: returned address must match the address issued one cycle earlier
  always_ff @(posedge clk) begin
    if (rst)                                                r_addr_err <= 1'b0;
    else if (r_inflight && (bus.rom_addr_return != r_last_addr)) r_addr_err <= 1'b1;
  end

  assign bus.addr_err = r_addr_err;
`endif
endmodule
`default_nettype wire
